// File: rtl/jtframe_dump_trigger.sv
// jtframe_dump_trigger: counts frames on vs falling edges and opens a capture window of N frames
module jtframe_dump_trigger #(
  parameter int CNTW    = 32,
  parameter int LENW    = 16,
  parameter int HOLDOFF = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vs,
  input  logic            downloading,
  input  logic            arm,
  input  logic [CNTW-1:0] start_frame,
  input  logic [LENW-1:0] frames,
  output logic [CNTW-1:0] frame_cnt,
  output logic            dump_en,
  output logic            dump_on,
  output logic            dump_off,
  output logic [1:0]      st
);
  localparam int HW = HOLDOFF < 1 ? 1 : $clog2(HOLDOFF + 1);
  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DONE} state_t;
  state_t          r_st, w_st_nxt;
  logic            r_vs_l, r_on, r_off, w_on, w_off, w_latch, w_tick, w_allow;
  logic [CNTW-1:0] r_cnt, r_start;
  logic [LENW-1:0] r_len, r_rem, w_rem_nxt;
  logic [HW-1:0]   r_hold;
  assign w_tick    = r_vs_l & ~vs;
  assign w_allow   = r_hold == '0;
  assign frame_cnt = r_cnt;
  assign dump_en   = r_st == ACTIVE;
  assign dump_on   = r_on;
  assign dump_off  = r_off;
  assign st        = r_st;
  always_comb begin
    w_st_nxt  = r_st;
    w_rem_nxt = r_rem;
    w_on      = 1'b0;
    w_off     = 1'b0;
    w_latch   = 1'b0;
    if (downloading) begin
      w_st_nxt = IDLE;
      w_off    = r_st == ACTIVE;
    end else begin
      case (r_st)
        IDLE, DONE: if (arm && frames != '0) begin
          w_st_nxt = WAIT;
          w_latch  = 1'b1;
        end
        WAIT: if (w_tick && w_allow && r_cnt >= r_start) begin
          w_st_nxt  = ACTIVE;
          w_on      = 1'b1;
          w_rem_nxt = r_len;
        end
        ACTIVE: if (w_tick) begin
          w_rem_nxt = r_rem - 1'b1;
          if (r_rem == LENW'(1)) begin
            w_st_nxt = DONE;
            w_off    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= IDLE;
      r_vs_l  <= 1'b0;
      r_on    <= 1'b0;
      r_off   <= 1'b0;
      r_cnt   <= '0;
      r_start <= '0;
      r_len   <= '0;
      r_rem   <= '0;
      r_hold  <= '0;
    end else begin
      r_st   <= w_st_nxt;
      r_vs_l <= vs;
      r_on   <= w_on;
      r_off  <= w_off;
      r_rem  <= w_rem_nxt;
      r_cnt  <= downloading ? '0 : r_cnt + CNTW'(w_tick);
      r_hold <= downloading ? HW'(HOLDOFF) : r_hold - HW'(w_tick && !w_allow);
      if (w_latch) begin
        r_start <= start_frame;
        r_len   <= frames;
      end
    end
  end
endmodule

// File: tb/tb_jtframe_dump_trigger.sv
// tb_jtframe_dump_trigger: directed stimulus with a frame-level model checked every cycle
module tb_jtframe_dump_trigger;
  logic        clk = 1'b0, rst, vs, downloading, arm;
  logic [7:0]  start_frame, frame_cnt;
  logic [15:0] frames;
  logic        dump_en, dump_on, dump_off;
  logic [1:0]  st;
  int n_tests = 0, n_fail = 0;
  jtframe_dump_trigger #(.CNTW(8), .LENW(16), .HOLDOFF(4)) dut (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading), .arm(arm),
    .start_frame(start_frame), .frames(frames), .frame_cnt(frame_cnt),
    .dump_en(dump_en), .dump_on(dump_on), .dump_off(dump_off), .st(st)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // model: mode 0 idle, 1 waiting, 2 in window, 3 finished; window length counted upward
  int m_cnt, m_hold, m_mode, m_seen, m_start, m_len, m_old;
  bit m_vsp, m_on, m_off, m_tick, m_ok, started = 0;
  always @(posedge clk) begin
    m_on = 0;
    m_off = 0;
    if (rst) begin
      m_cnt = 0; m_hold = 0; m_mode = 0; m_seen = 0; m_start = 0; m_len = 0; m_vsp = 0;
      started = 1;
    end else begin
      m_tick = m_vsp && !vs;
      m_vsp = vs;
      if (downloading) begin
        m_off = m_mode == 2;
        m_mode = 0;
        m_cnt = 0;
        m_hold = 4;
      end else begin
        m_old = m_cnt;
        m_ok = m_hold == 0;
        if (m_tick) begin
          m_cnt = (m_cnt + 1) % 256;
          if (m_hold > 0) m_hold--;
        end
        if ((m_mode == 0 || m_mode == 3) && arm && frames != 0) begin
          m_start = start_frame; m_len = frames; m_mode = 1;
        end else if (m_mode == 1 && m_tick && m_ok && m_old >= m_start) begin
          m_mode = 2; m_on = 1; m_seen = 0;
        end else if (m_mode == 2 && m_tick) begin
          m_seen++;
          if (m_seen == m_len) begin m_mode = 3; m_off = 1; end
        end
      end
    end
  end
  always @(negedge clk) if (started)
    chk("cycle", {frame_cnt, dump_en, dump_on, dump_off, st},
        {m_cnt[7:0], m_mode == 2, m_on, m_off, m_mode[1:0]});
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic tk();
    vs = 1; cyc(2);
    vs = 0; cyc(1);
  endtask
  task automatic do_arm(input logic [7:0] s, input logic [15:0] f);
    start_frame = s; frames = f; arm = 1; cyc(1);
    arm = 0; cyc(1);
  endtask
  initial begin
    rst = 1; vs = 0; downloading = 0; arm = 0; start_frame = 0; frames = 0;
    cyc(3);
    chk("rst_cnt", frame_cnt, 0); chk("rst_st", st, 0); chk("rst_en", dump_en, 0);
    rst = 0;
    repeat (5) tk();
    chk("t1_cnt", frame_cnt, 5); chk("t1_st", st, 0); chk("t1_en", dump_en, 0);
    rst = 1; cyc(2); rst = 0;
    do_arm(3, 2); chk("t2_wait", st, 1);
    repeat (3) tk(); chk("t2_pre_cnt", frame_cnt, 3); chk("t2_pre_st", st, 1);
    tk(); chk("t2_on", dump_on, 1); chk("t2_en", dump_en, 1); chk("t2_on_cnt", frame_cnt, 4);
    cyc(1); chk("t2_on_pulse", dump_on, 0);
    tk(); chk("t2_mid_en", dump_en, 1); chk("t2_mid_cnt", frame_cnt, 5);
    tk(); chk("t2_off", dump_off, 1); chk("t2_done", st, 3); chk("t2_off_en", dump_en, 0);
    cyc(1); chk("t2_off_pulse", dump_off, 0);
    repeat (4) tk(); chk("t3_cnt", frame_cnt, 10);
    do_arm(1, 1); chk("t3_wait", st, 1);
    tk(); chk("t3_on", dump_on, 1); chk("t3_cnt11", frame_cnt, 11);
    tk(); chk("t3_off", dump_off, 1); chk("t3_done", st, 3);
    do_arm(0, 3); tk(); chk("t4_active", st, 2);
    downloading = 1; cyc(1);
    chk("t4_off", dump_off, 1); chk("t4_cnt", frame_cnt, 0); chk("t4_idle", st, 0); chk("t4_en", dump_en, 0);
    cyc(1); chk("t4_single_off", dump_off, 0);
    downloading = 0; cyc(1);
    do_arm(0, 2); repeat (4) tk();
    chk("t4_hold_st", st, 1); chk("t4_hold_cnt", frame_cnt, 4);
    tk(); chk("t4_on5", dump_on, 1);
    tk(); tk(); chk("t4_done", st, 3);
    downloading = 1; cyc(1); downloading = 0; cyc(1);
    do_arm(5, 0); chk("t5_zero_len", st, 0);
    do_arm(8, 1); do_arm(2, 5); chk("t5_wait", st, 1);
    repeat (8) tk(); chk("t5_still_wait", st, 1); chk("t5_cnt", frame_cnt, 8);
    tk(); chk("t5_on", dump_on, 1); chk("t5_en", dump_en, 1);
    tk(); chk("t5_off", dump_off, 1); chk("t5_done", st, 3);
    cyc(20); chk("t5_frozen", frame_cnt, 10);
    rst = 1; cyc(2); rst = 0;
    repeat (255) tk(); chk("t6_cnt255", frame_cnt, 255);
    tk(); chk("t6_wrap", frame_cnt, 0); chk("t6_idle", st, 0);
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
